// File: rtl/lights_pkg.sv
// Shared mode encoding and pattern helpers for the light sweeper block.
package lights_pkg;

    typedef enum logic [1:0] {
        CALM    = 2'b00,
        SWEEP_R = 2'b01,
        SWEEP_L = 2'b10,
        BOUNCE  = 2'b11
    } mode_t;

    // Patterns are built at this width and sliced down to N by the user.
    localparam int MAX_N = 64;

    function automatic logic [MAX_N-1:0] ends_pat(input int n);
        logic [MAX_N-1:0] p;
        p        = '0;
        p[n-1]   = 1'b1;
        p[0]     = 1'b1;
        return p;
    endfunction

    function automatic logic [MAX_N-1:0] mid_pat(input int n);
        logic [MAX_N-1:0] p;
        p        = '0;
        p[n/2]   = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/light_sweeper_tick_prescaler.sv
// Step-rate prescaler: one tick every DIV enabled cycles, frozen while en is low.
module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // With DIV = 1 the counter sits at zero and tick degenerates to en.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/light_sweeper.sv
// N-light pattern sequencer: calm, sweep right/left and bounce, stepped by a prescaler.
module light_sweeper
    import lights_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [N-1:0] out,
    output logic         step
);

    localparam logic [MAX_N-1:0] ENDS_W = ends_pat(N);
    localparam logic [MAX_N-1:0] MID_W  = mid_pat(N);
    localparam logic [N-1:0]     ENDS   = ENDS_W[N-1:0];
    localparam logic [N-1:0]     MID    = MID_W[N-1:0];

    mode_t        active, active_nxt, req;
    logic         dir, dir_nxt;
    logic [N-1:0] out_nxt;
    logic         tick;

    assign req = mode_t'(mode);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    always_comb begin
        active_nxt = active;
        dir_nxt    = dir;
        out_nxt    = out;
        if (tick) begin
            if (req != active) begin
                // Entry step: sweeps continue from a one-hot position rather than jumping.
                active_nxt = req;
                dir_nxt    = 1'b0;
                if (req == CALM)
                    out_nxt = ENDS;
                else if ($onehot(out))
                    out_nxt = out;
                else
                    out_nxt = MID;
            end else begin
                case (active)
                    CALM:    out_nxt = (out == ENDS) ? MID : ENDS;
                    SWEEP_R: out_nxt = {out[0], out[N-1:1]};
                    SWEEP_L: out_nxt = {out[N-2:0], out[N-1]};
                    BOUNCE: begin
                        if (!dir) begin
                            out_nxt = {out[N-2:0], 1'b0};
                            if (out[N-1]) begin
                                out_nxt = {1'b0, out[N-1:1]};
                                dir_nxt = 1'b1;
                            end
                        end else begin
                            out_nxt = {1'b0, out[N-1:1]};
                            if (out[0]) begin
                                out_nxt = {out[N-2:0], 1'b0};
                                dir_nxt = 1'b0;
                            end
                        end
                    end
                    default: out_nxt = ENDS;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= ENDS;
            active <= CALM;
            dir    <= 1'b0;
            step   <= 1'b0;
        end else begin
            out    <= out_nxt;
            active <= active_nxt;
            dir    <= dir_nxt;
            step   <= tick;
        end
    end

endmodule

// File: tb/tb_light_sweeper.sv
// Directed bench for light_sweeper at N=4/DIV=1 and N=8/DIV=3 with a per-cycle scoreboard.
module tb_light_sweeper;

    logic       clk = 1'b0;
    logic       reset4, en4, reset8, en8;
    logic [1:0] mode4, mode8;
    logic [3:0] out4;
    logic [7:0] out8;
    logic       step4, step8;

    typedef struct {
        logic [7:0] o;
        logic       s;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       sel8     = 1'b0;
    logic [7:0] prev8;

    always #5 clk = ~clk;

    light_sweeper #(.N(4), .DIV(1)) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .mode(mode4), .out(out4), .step(step4)
    );

    light_sweeper #(.N(8), .DIV(3)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .out(out8), .step(step8)
    );

    // Queue the expected post-edge values, clock once, then pop and compare.
    task automatic run(input string tag, input logic [7:0] o, input logic s);
        exp_t       e;
        logic [7:0] obs_o;
        logic       obs_s;
        sb.push_back('{o: o, s: s, tag: tag});
        @(posedge clk);
        #1;
        e     = sb.pop_front();
        obs_o = sel8 ? out8 : {4'b0000, out4};
        obs_s = sel8 ? step8 : step4;
        n_assert++;
        assert (obs_o === e.o) else begin
            n_fail++;
            $error("FAIL %s out: got %b expected %b", e.tag, obs_o, e.o);
        end
        n_assert++;
        assert (obs_s === e.s) else begin
            n_fail++;
            $error("FAIL %s step: got %b expected %b", e.tag, obs_s, e.s);
        end
    endtask

    // One DIV=3 step of dut8: two idle cycles holding prev8, then the new value with step.
    task automatic tk8(input string tag, input logic [7:0] o);
        run(tag, prev8, 1'b0);
        run(tag, prev8, 1'b0);
        run(tag, o, 1'b1);
        prev8 = o;
    endtask

    initial begin
        reset4 = 1'b1; en4 = 1'b0; mode4 = 2'b00;
        reset8 = 1'b1; en8 = 1'b0; mode8 = 2'b00;
        #1;

        run("rst4", 8'b1001, 1'b0);
        reset4 = 1'b0; en4 = 1'b1; mode4 = 2'b00;
        run("calm1", 8'b0100, 1'b1);
        run("calm2", 8'b1001, 1'b1);
        run("calm3", 8'b0100, 1'b1);

        mode4 = 2'b01;
        run("swr_entry", 8'b0100, 1'b1);
        run("swr1", 8'b0010, 1'b1);
        run("swr2", 8'b0001, 1'b1);
        run("swr_wrap", 8'b1000, 1'b1);
        run("swr4", 8'b0100, 1'b1);
        run("swr5", 8'b0010, 1'b1);
        run("swr6", 8'b0001, 1'b1);

        mode4 = 2'b11;
        run("bnc_entry", 8'b0001, 1'b1);
        run("bnc1", 8'b0010, 1'b1);
        run("bnc2", 8'b0100, 1'b1);
        run("bnc_top", 8'b1000, 1'b1);
        run("bnc_rev", 8'b0100, 1'b1);
        run("bnc5", 8'b0010, 1'b1);
        run("bnc_bot", 8'b0001, 1'b1);
        run("bnc_rev2", 8'b0010, 1'b1);

        mode4 = 2'b00;
        run("calm_entry", 8'b1001, 1'b1);
        en4 = 1'b0;
        run("hold4", 8'b1001, 1'b0);
        en4 = 1'b1;
        run("resume4", 8'b0100, 1'b1);

        sel8 = 1'b1;
        run("rst8", 8'b10000001, 1'b0);
        reset8 = 1'b0; en8 = 1'b1; mode8 = 2'b10;
        prev8 = 8'b10000001;
        tk8("swl_entry", 8'b00010000);
        tk8("swl1", 8'b00100000);

        run("pre_gap", prev8, 1'b0);
        run("pre_gap", prev8, 1'b0);
        en8 = 1'b0;
        run("gap1", prev8, 1'b0);
        run("gap2", prev8, 1'b0);
        en8 = 1'b1;
        run("gap_tick", 8'b01000000, 1'b1);
        prev8 = 8'b01000000;

        mode8 = 2'b11;
        tk8("b8_entry", 8'b01000000);
        tk8("b8_top", 8'b10000000);
        tk8("b8_rev", 8'b01000000);
        tk8("b8_d1", 8'b00100000);
        tk8("b8_d2", 8'b00010000);
        tk8("b8_d3", 8'b00001000);
        tk8("b8_d4", 8'b00000100);

        run("pend1", prev8, 1'b0);
        run("pend2", prev8, 1'b0);
        reset8 = 1'b1;
        run("rst_mid", 8'b10000001, 1'b0);
        reset8 = 1'b0;
        prev8 = 8'b10000001;
        tk8("post_rst_entry", 8'b00010000);
        tk8("post_rst_adv", 8'b00100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
